// File: rtl/adcsnap_pkg.sv
// adcsnap_pkg: shared state encoding and ctrl/status bit positions for the ADC snap capture path
package adcsnap_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam int CTRL_ARM      = 0;
  localparam int CTRL_TRIG_SEL = 1;
  localparam int CTRL_WE_SEL   = 2;
  localparam int ST_DONE       = 31;
  localparam int ST_CAPT       = 30;
  localparam int ST_ARMED      = 29;
endpackage

// File: rtl/adcsnap_edge_det.sv
// adcsnap_edge_det: rising-edge detector whose history register resets to RST_VAL
// Ports: i_clk clock, i_rst_n sync active-low reset, i_d level input, o_rise high when i_d is high now and was low last cycle
module adcsnap_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);
  logic r_prev;
  always_ff @(posedge i_clk) r_prev <= !i_rst_n ? RST_VAL : i_d;
  assign o_rise = i_d & ~r_prev;
endmodule

// File: rtl/adcsnap_capture_ctrl.sv
// adcsnap_capture_ctrl: arm/trigger snapshot controller streaming 2^ADDR_W ADC words into the snap BRAM
// Ports: user_clk clock; user_rst_n sync active-low reset; ctrl [0] arm [1] trig_sel [2] we_sel;
//   din/din_valid ADC sample and qualifier; trig_in external trigger level;
//   bram_addr/bram_data/bram_we BRAM write port (1-cycle latency); status [31] done [30] capturing [29] armed [ADDR_W:0] words;
//   tstamp trigger-cycle timestamp, present only when ADCSNAP_TSTAMP_EN is defined
module adcsnap_capture_ctrl
  import adcsnap_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig_in,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status
`ifdef ADCSNAP_TSTAMP_EN
  , output logic [31:0]     tstamp
`endif
);
  state_t              r_state;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_we;
  logic                w_arm;
  logic                w_trig;
  logic                w_wr_ok;
  logic                w_wr;
  logic                w_last;
  logic [31:0]         w_status;
  logic                w_unused;
  // History resets high so an arm bit held through reset must drop before it can fire
  adcsnap_edge_det #(.RST_VAL(1'b1)) u_arm_edge (
    .i_clk   (user_clk),
    .i_rst_n (user_rst_n),
    .i_d     (ctrl[CTRL_ARM]),
    .o_rise  (w_arm)
  );
  assign w_unused = ^ctrl[31:3];
  assign w_trig   = ~ctrl[CTRL_TRIG_SEL] | trig_in;
  assign w_wr_ok  = ~ctrl[CTRL_WE_SEL] | din_valid;
  // The trigger-coincident sample is written straight from ARMED
  assign w_wr     = ((r_state == ARMED && w_trig) || r_state == CAPTURE) && w_wr_ok;
  assign w_last   = &r_count[ADDR_W-1:0];
  always_comb begin
    w_status           = '0;
    w_status[ST_DONE]  = r_state == DONE;
    w_status[ST_CAPT]  = r_state == CAPTURE;
    w_status[ST_ARMED] = r_state == ARMED;
    w_status[ADDR_W:0] = r_count;
  end
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_addr  <= r_count[ADDR_W-1:0];
        r_data  <= din;
        r_count <= r_count + (ADDR_W+1)'(1);
      end
      case (r_state)
        IDLE, DONE: if (w_arm) begin
          r_state <= ARMED;
          r_count <= '0;
        end
        ARMED:   if (w_trig) r_state <= (w_wr && w_last) ? DONE : CAPTURE;
        CAPTURE: if (w_wr && w_last) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bram_addr = r_addr;
  assign bram_data = r_data;
  assign bram_we   = r_we;
  assign status    = w_status;
`ifdef ADCSNAP_TSTAMP_EN
  logic [31:0] r_cyc;
  logic [31:0] r_tstamp;
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      r_cyc    <= '0;
      r_tstamp <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (r_state == ARMED && w_trig) r_tstamp <= r_cyc;
    end
  end
  assign tstamp = r_tstamp;
`endif
endmodule

// File: tb/tb_adcsnap_capture_ctrl.sv
// tb_adcsnap_capture_ctrl: table vectors, directed corner sequences and random stimulus against a reference model
module tb_adcsnap_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_DONE = 3;
  logic          user_clk = 1'b0;
  logic          user_rst_n = 1'b0;
  logic [31:0]   ctrl = '0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          trig_in = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          bram_we;
  logic [31:0]   status;
`ifdef ADCSNAP_TSTAMP_EN
  logic [31:0]   tstamp;
`endif
  adcsnap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .ctrl       (ctrl),
    .din        (din),
    .din_valid  (din_valid),
    .trig_in    (trig_in),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .bram_we    (bram_we),
    .status     (status)
`ifdef ADCSNAP_TSTAMP_EN
    , .tstamp   (tstamp)
`endif
  );
  always #5 user_clk = ~user_clk;
  int checks = 0;
  int failures = 0;
  int m_mode;
  int m_n;
  bit m_prev;
  bit e_we;
  bit e_chk_ad;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_data;
  logic [31:0]   m_cyc;
  logic [31:0]   m_ts;
  typedef struct {
    logic        rn;
    logic [31:0] c;
    logic [31:0] d;
    logic        v;
    logic        t;
    logic        we;
    logic [31:0] st;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] e_status();
    return {m_mode == M_DONE, m_mode == M_CAPT, m_mode == M_ARMED, 29'(m_n)};
  endfunction
  task automatic model(input logic rn, input logic [31:0] c, input logic [31:0] d, input logic v, input logic t);
    int old;
    bit arm_ev, ok, trg;
    if (!rn) begin
      m_mode = M_IDLE; m_n = 0; m_prev = 1'b1; e_we = 1'b0; e_addr = '0; e_data = '0;
      e_chk_ad = 1'b1; m_cyc = '0; m_ts = '0;
    end else begin
      old = m_mode;
      arm_ev = c[0] && !m_prev;
      m_prev = c[0];
      ok = c[2] ? v : 1'b1;
      trg = c[1] ? t : 1'b1;
      e_we = (old == M_CAPT || (old == M_ARMED && trg)) && ok;
      e_chk_ad = e_we;
      if (old == M_ARMED && trg) begin
        m_mode = M_CAPT;
        m_ts = m_cyc;
      end
      if (e_we) begin
        e_addr = AW'(m_n);
        e_data = d;
        m_n++;
      end
      if (m_mode == M_CAPT && m_n == (1 << AW)) m_mode = M_DONE;
      if ((old == M_IDLE || old == M_DONE) && arm_ev) begin
        m_mode = M_ARMED;
        m_n = 0;
      end
      m_cyc = m_cyc + 32'd1;
    end
  endtask
  task automatic cyc(input logic rn, input logic [31:0] c, input logic [31:0] d, input logic v, input logic t);
    user_rst_n = rn; ctrl = c; din = d; din_valid = v; trig_in = t;
    model(rn, c, d, v, t);
    @(posedge user_clk);
    #1;
    chk("we", 32'(bram_we), 32'(e_we));
    chk("status", status, e_status());
    if (e_chk_ad) begin
      chk("addr", 32'(bram_addr), 32'(e_addr));
      chk("data", bram_data, e_data);
    end
`ifdef ADCSNAP_TSTAMP_EN
    chk("tstamp", tstamp, m_ts);
`endif
  endtask
  initial begin
    int nw, nb, kd;
    bit hit, seen_arm;
    logic [31:0] first_d;
    tbl[0] = '{1'b0, 32'h1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h1, 32'h12, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h1, 32'h13, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 32'h0, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 32'h3, 32'h15, 1'b1, 1'b1, 1'b0, 32'h2000_0000};
    tbl[5] = '{1'b1, 32'h3, 32'h16, 1'b1, 1'b0, 1'b0, 32'h2000_0000};
    tbl[6] = '{1'b1, 32'h1, 32'h17, 1'b0, 1'b0, 1'b1, 32'h4000_0001};
    tbl[7] = '{1'b1, 32'h1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h4000_0002};
    tbl[8] = '{1'b0, 32'h1, 32'h19, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[9] = '{1'b1, 32'h1, 32'h1a, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rn, tbl[i].c, tbl[i].d, tbl[i].v, tbl[i].t);
      chk($sformatf("tbl%0d_we", i), 32'(bram_we), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_status", i), status, tbl[i].st);
    end
    chk("tbl_reset_addr", 32'(bram_addr), 32'h0);
    cyc(1, 32'h0, 32'h0, 0, 0);
    nw = 0;
    first_d = '0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 32'h1, 32'(i), 0, 0);
      if (bram_we) begin
        if (nw == 0) first_d = bram_data;
        chk("ramp_addr", 32'(bram_addr), 32'(nw));
        nw++;
      end
    end
    chk("ramp_writes", 32'(nw), 32'd16);
    chk("ramp_first", first_d, 32'd1);
    chk("ramp_done", status, 32'h8000_0010);
    cyc(1, 32'h0, 32'h0, 0, 0);
    nb = 0;
    for (int k = 0; k <= 50; k++) begin
      cyc(1, 32'h3, (k == 50) ? 32'hAB : 32'(k), 1, k == 50);
      if (k < 50) nb += int'(bram_we);
    end
    chk("ext_no_early", 32'(nb), 32'd0);
    chk("ext_we", 32'(bram_we), 32'd1);
    chk("ext_addr", 32'(bram_addr), 32'd0);
    chk("ext_data", bram_data, 32'hAB);
    for (int k = 0; k < 20; k++) cyc(1, 32'h3, $urandom, 1, 0);
    chk("ext_done", status, 32'h8000_0010);
    cyc(1, 32'h0, 32'h0, 0, 0);
    cyc(1, 32'h5, 32'h0, 0, 0);
    nw = 0;
    kd = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1, 32'h5, $urandom, k[0], 0);
      nw += int'(bram_we);
      if (status[31] && kd == 0) kd = k;
    end
    chk("valid_writes", 32'(nw), 32'd16);
    chk("valid_span", 32'(kd), 32'd31);
    cyc(1, 32'h0, 32'h0, 0, 0);
    cyc(1, 32'h1, 32'h0, 0, 0);
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      cyc(1, 32'h1, $urandom, 0, 0);
      hit = status[AW:0] == 5'd7;
    end
    chk("mid_reached7", 32'(hit), 32'd1);
    cyc(0, 32'h1, 32'h77, 0, 0);
    chk("mid_rst_we", 32'(bram_we), 32'd0);
    chk("mid_rst_status", status, 32'd0);
    chk("mid_rst_addr", 32'(bram_addr), 32'd0);
    chk("mid_rst_data", bram_data, 32'd0);
    cyc(1, 32'h0, 32'h0, 0, 0);
    cyc(1, 32'h1, 32'h0, 0, 0);
    cyc(1, 32'h1, 32'h55, 0, 0);
    chk("restart_we", 32'(bram_we), 32'd1);
    chk("restart_addr", 32'(bram_addr), 32'd0);
    chk("restart_data", bram_data, 32'h55);
    seen_arm = 1'b0;
    cyc(1, 32'h0, 32'h1, 0, 0);
    cyc(1, 32'h1, 32'h2, 0, 0);
    for (int k = 0; k < 20; k++) begin
      seen_arm |= status[29];
      cyc(1, 32'h1, $urandom, 0, 0);
    end
    chk("cap_arm_ignored", 32'(seen_arm), 32'd0);
    chk("cap_done", status, 32'h8000_0010);
    cyc(1, 32'h0, 32'h0, 0, 0);
    cyc(1, 32'h3, 32'h0, 0, 0);
    chk("done_rearm", status, 32'h2000_0000);
    for (int k = 0; k < 5; k++) cyc(1, 32'h3, 32'h0, 0, 0);
    cyc(1, 32'h3, 32'hC0DE, 1, 1);
    chk("ts_trig_we", 32'(bram_we), 32'd1);
    for (int k = 0; k < 20; k++) cyc(1, 32'h3, $urandom, 1, 0);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] c;
      c = ctrl;
      if ($urandom_range(0, 29) == 0) c[0] = ~c[0];
      if ($urandom_range(0, 19) == 0) c[1] = ~c[1];
      if ($urandom_range(0, 19) == 0) c[2] = ~c[2];
      if ($urandom_range(0, 9) == 0) c[31:3] = 29'($urandom);
      cyc($urandom_range(0, 299) != 0, c, $urandom, 1'($urandom), $urandom_range(0, 7) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
